// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: wait-state memory slave for the LC-3 controller; optional access counter via LC3_MEM_RESP_STATS_EN
module lc3_mem_responder #(
   parameter int WAIT_CYCLES = 3,
   parameter int DEPTH_LOG2  = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  state,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        complete,
   output logic [15:0] rdata,
   output logic        busy,
   output logic        addr_err
`ifdef LC3_MEM_RESP_STATS_EN
   ,
   output logic [15:0] access_count
`endif
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} fsm_t;
   fsm_t fsm, fsm_nxt;
   logic [3:0]  cnt, cnt_nxt, cap_code;
   logic [15:0] cap_addr, cap_wdata;
   logic        do_access, oor, cap_we;
   logic [DEPTH_LOG2-1:0] idx;
   logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

   function automatic logic is_req(input logic [3:0] c);
      return c == 4'd2 || c == 4'd5 || c == 4'd6;
   endfunction

   assign oor    = (cap_addr >> DEPTH_LOG2) != 16'd0;
   assign cap_we = cap_code == 4'd6;
   assign idx    = cap_addr[DEPTH_LOG2-1:0];

   // next-state: capture in IDLE, count down or abort in WAIT, hold DONE until request drops
   always_comb begin
      fsm_nxt   = fsm;
      cnt_nxt   = cnt;
      do_access = 1'b0;
      case (fsm)
         S_IDLE: if (is_req(state)) begin
            fsm_nxt = S_WAIT;
            cnt_nxt = 4'(WAIT_CYCLES);
         end
         S_WAIT: if (state != cap_code) begin
            fsm_nxt = S_IDLE;
            cnt_nxt = 4'd0;
         end else if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
         end else begin
            fsm_nxt   = S_DONE;
            do_access = 1'b1;
         end
         S_DONE: if (!is_req(state)) fsm_nxt = S_IDLE;
         default: fsm_nxt = S_IDLE;
      endcase
   end

   // state register, request capture and registered handshake outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm       <= S_IDLE;
         cnt       <= 4'd0;
         complete  <= 1'b0;
         busy      <= 1'b0;
         addr_err  <= 1'b0;
         rdata     <= 16'h0000;
         cap_addr  <= 16'h0000;
         cap_wdata <= 16'h0000;
         cap_code  <= 4'd0;
      end else begin
         fsm      <= fsm_nxt;
         cnt      <= cnt_nxt;
         busy     <= fsm_nxt != S_IDLE;
         complete <= fsm_nxt == S_DONE;
         addr_err <= fsm_nxt == S_DONE && oor;
         if (fsm == S_IDLE && is_req(state)) begin
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cap_code  <= state;
         end
         if (do_access && (oor || !cap_we)) rdata <= oor ? 16'h0000 : mem[idx];
      end
   end

   // memory array is never reset; a reset forces IDLE so no pending store can land
   always_ff @(posedge clock) begin
      if (do_access && cap_we && !oor) mem[idx] <= cap_wdata;
   end

`ifdef LC3_MEM_RESP_STATS_EN
   // count completed handshakes (DONE -> IDLE), wrapping naturally
   always_ff @(posedge clock or posedge reset) begin
      if (reset) access_count <= 16'd0;
      else if (fsm == S_DONE && fsm_nxt == S_IDLE) access_count <= access_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed checks of handshake latency, abort, out-of-range and reset behaviour
module tb_lc3_mem_responder;
   localparam int W = 3;
   logic        clock = 1'b0, reset = 1'b1;
   logic [3:0]  state = 4'd0, z_state = 4'd0;
   logic [15:0] addr = 16'h0, wdata = 16'h0;
   logic        complete, busy, addr_err, z_complete, z_busy, z_addr_err;
   logic [15:0] rdata, z_rdata;
`ifdef LC3_MEM_RESP_STATS_EN
   logic [15:0] access_count, z_access_count;
`endif
   int checks = 0, failures = 0;

   lc3_mem_responder #(.WAIT_CYCLES(W), .DEPTH_LOG2(8)) dut (
      .clock(clock), .reset(reset), .state(state), .addr(addr), .wdata(wdata),
      .complete(complete), .rdata(rdata), .busy(busy), .addr_err(addr_err)
`ifdef LC3_MEM_RESP_STATS_EN
      , .access_count(access_count)
`endif
   );

   lc3_mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut_z (
      .clock(clock), .reset(reset), .state(z_state), .addr(addr), .wdata(wdata),
      .complete(z_complete), .rdata(z_rdata), .busy(z_busy), .addr_err(z_addr_err)
`ifdef LC3_MEM_RESP_STATS_EN
      , .access_count(z_access_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic xfer(input logic [3:0] code, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_err, input logic chk_rd);
      state = code;
      addr  = a;
      wdata = d;
      tick();
      check("busy_cap", 32'(busy), 32'd1);
      repeat (W) tick();
      check("lat_early", 32'(complete), 32'd0);
      tick();
      check("lat_done", 32'(complete), 32'd1);
      check("addr_err", 32'(addr_err), 32'(exp_err));
      if (chk_rd) check("rdata", 32'(rdata), 32'(exp_rd));
      state = 4'd0;
      tick();
      check("release", 32'(complete), 32'd0);
      check("idle", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      state = 4'd0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #20;
      check("rst_complete", 32'(complete), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
`ifdef LC3_MEM_RESP_STATS_EN
      check("rst_count", 32'(access_count), 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      tick();
      // store then read back at 5-edge latency
      xfer(4'd6, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 1'b0);
      xfer(4'd5, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 1'b1);
      // DONE holds while the request code persists
      state = 4'd2;
      addr  = 16'h0010;
      repeat (W + 4) tick();
      check("done_hold", 32'(complete), 32'd1);
      check("fetch_rdata", 32'(rdata), 32'h0000BEEF);
      state = 4'd0;
      tick();
      check("done_release", 32'(complete), 32'd0);
      // top in-range word
      xfer(4'd6, 16'h00FF, 16'h0F0F, 16'h0, 1'b0, 1'b0);
      xfer(4'd5, 16'h00FF, 16'h0, 16'h0F0F, 1'b0, 1'b1);
      // aborted store leaves prior contents
      xfer(4'd6, 16'h0020, 16'hAAAA, 16'h0, 1'b0, 1'b0);
      state = 4'd6;
      addr  = 16'h0020;
      wdata = 16'h1234;
      tick();
      tick();
      check("abort_wait_busy", 32'(busy), 32'd1);
      state = 4'd0;
      tick();
      check("abort_complete", 32'(complete), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (W + 2) tick();
      check("abort_never_done", 32'(complete), 32'd0);
      xfer(4'd5, 16'h0020, 16'h0, 16'hAAAA, 1'b0, 1'b1);
      // out-of-range read and aliasing store
      xfer(4'd5, 16'h0100, 16'h0, 16'h0000, 1'b1, 1'b1);
      xfer(4'd6, 16'h0110, 16'h5555, 16'h0000, 1'b1, 1'b1);
      xfer(4'd5, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 1'b1);
      // reset during DONE of a store: store already committed
      state = 4'd6;
      addr  = 16'h0030;
      wdata = 16'h1111;
      repeat (W + 2) tick();
      check("pre_rst_done", 32'(complete), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_done_complete", 32'(complete), 32'd0);
      check("rst_done_busy", 32'(busy), 32'd0);
      check("rst_done_rdata", 32'(rdata), 32'd0);
      state = 4'd0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      xfer(4'd5, 16'h0030, 16'h0, 16'h1111, 1'b0, 1'b1);
      // reset during WAIT of a store: store dropped
      xfer(4'd6, 16'h0040, 16'h7777, 16'h0, 1'b0, 1'b0);
      state = 4'd6;
      addr  = 16'h0040;
      wdata = 16'h2222;
      tick();
      tick();
      check("pre_rst_wait", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rst_wait_complete", 32'(complete), 32'd0);
      check("rst_wait_busy", 32'(busy), 32'd0);
      state = 4'd0;
      @(negedge clock);
      reset = 1'b0;
      tick();
      xfer(4'd5, 16'h0040, 16'h0, 16'h7777, 1'b0, 1'b1);
      // zero wait states
      z_state = 4'd2;
      tick();
      check("z_busy", 32'(z_busy), 32'd1);
      check("z_early", 32'(z_complete), 32'd0);
      tick();
      check("z_done", 32'(z_complete), 32'd1);
      z_state = 4'd0;
      tick();
      check("z_release", 32'(z_complete), 32'd0);
`ifdef LC3_MEM_RESP_STATS_EN
      do_reset();
      tick();
      for (int c = 0; c < 16; c++) begin
         state = 4'(c);
         addr  = 16'h0050;
         repeat (W + 3) tick();
         state = 4'd0;
         tick();
         tick();
      end
      check("count_sweep", 32'(access_count), 32'd3);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
